// File: rtl/edit_cmd_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | edit_cmd_sequencer: keypad edge-detect/arbiter, cursor+size owner, issues     |
// | insert/delete commands and sequences evaluation. Option: EDIT_REJECT_COUNT_EN |
// | rev 1.0                                                                       |
// +-----------------------------------------------------------------------------+
module edit_cmd_sequencer #(
   parameter int depth = 5,
   parameter int width = 8,
   localparam int pw = $clog2(depth + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [15:0]      b,
   input  logic             del,
   input  logic             ptrLeft,
   input  logic             ptrRight,
   input  logic             eval,
   output logic             cmd_valid,
   output logic             cmd_op,
   output logic [pw-1:0]    cmd_pos,
   output logic [width-1:0] cmd_data,
   input  logic             ds_ready,
   output logic             eval_start,
   input  logic             eval_done,
   output logic [pw-1:0]    ptr,
   output logic [pw-1:0]    size,
   output logic             busy,
`ifdef EDIT_REJECT_COUNT_EN
   output logic [7:0]       reject_count,
`endif
   output logic             rejected
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      EVAL_WAIT = 2'd2
   } state_t;

   localparam logic [pw-1:0] c_one   = pw'(1);
   localparam logic [pw-1:0] c_depth = pw'(depth);

   state_t            state, state_nx;
   logic [15:0]       b_prev;
   logic              del_prev, left_prev, right_prev, eval_prev;
   logic [15:0]       b_edge;
   logic              del_edge, left_edge, right_edge, eval_edge;
   logic [3:0]        key_idx;
   logic [pw-1:0]     ptr_nx, size_nx, pos_nx;
   logic [width-1:0]  data_nx;
   logic              op_nx, eval_start_nx, rejected_nx;

   assign b_edge     = b & ~b_prev;
   assign del_edge   = del & ~del_prev;
   assign left_edge  = ptrLeft & ~left_prev;
   assign right_edge = ptrRight & ~right_prev;
   assign eval_edge  = eval & ~eval_prev;

   assign cmd_valid = (state == ISSUE);
   assign busy      = (state != IDLE);

   always_comb begin
      key_idx = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (b_edge[i]) key_idx = 4'(i);
      end
   end

   always_comb begin
      state_nx      = state;
      ptr_nx        = ptr;
      size_nx       = size;
      op_nx         = cmd_op;
      pos_nx        = cmd_pos;
      data_nx       = cmd_data;
      eval_start_nx = 1'b0;
      rejected_nx   = 1'b0;
      case (state)
         IDLE: begin
            // Only the highest-priority event this cycle is considered.
            if (eval_edge) begin
               if (size == '0) rejected_nx = 1'b1;
               else begin
                  eval_start_nx = 1'b1;
                  state_nx      = EVAL_WAIT;
               end
            end else if (del_edge) begin
               if (ptr == '0) rejected_nx = 1'b1;
               else begin
                  op_nx    = 1'b1;
                  pos_nx   = ptr - c_one;
                  data_nx  = '0;
                  state_nx = ISSUE;
               end
            end else if (left_edge) begin
               if (ptr == '0) rejected_nx = 1'b1;
               else           ptr_nx      = ptr - c_one;
            end else if (right_edge) begin
               if (ptr < size) ptr_nx      = ptr + c_one;
               else            rejected_nx = 1'b1;
            end else if (b_edge != 16'd0) begin
               if (!$onehot(b_edge) || size == c_depth) rejected_nx = 1'b1;
               else begin
                  op_nx    = 1'b0;
                  pos_nx   = ptr;
                  data_nx  = width'(key_idx);
                  state_nx = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (ds_ready) begin
               if (cmd_op) begin
                  ptr_nx  = ptr - c_one;
                  size_nx = size - c_one;
               end else begin
                  ptr_nx  = ptr + c_one;
                  size_nx = size + c_one;
               end
               state_nx = IDLE;
            end
         end
         EVAL_WAIT: begin
            if (eval_done) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         ptr        <= '0;
         size       <= '0;
         cmd_op     <= 1'b0;
         cmd_pos    <= '0;
         cmd_data   <= '0;
         eval_start <= 1'b0;
         rejected   <= 1'b0;
         b_prev     <= '0;
         del_prev   <= 1'b0;
         left_prev  <= 1'b0;
         right_prev <= 1'b0;
         eval_prev  <= 1'b0;
      end else begin
         state      <= state_nx;
         ptr        <= ptr_nx;
         size       <= size_nx;
         cmd_op     <= op_nx;
         cmd_pos    <= pos_nx;
         cmd_data   <= data_nx;
         eval_start <= eval_start_nx;
         rejected   <= rejected_nx;
         b_prev     <= b;
         del_prev   <= del;
         left_prev  <= ptrLeft;
         right_prev <= ptrRight;
         eval_prev  <= eval;
      end
   end

`ifdef EDIT_REJECT_COUNT_EN
   always_ff @(posedge clock) begin
      if (reset)                                reject_count <= 8'd0;
      else if (rejected_nx && reject_count != 8'hFF) reject_count <= reject_count + 8'd1;
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_edit_cmd_sequencer.sv
`default_nettype none
// Directed table-driven bench for edit_cmd_sequencer with a small data-store model.
module tb_edit_cmd_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] b;
   logic        del, ptrLeft, ptrRight, eval, ds_ready, eval_done;
   logic        cmd_valid, cmd_op, eval_start, busy, rejected;
   logic [2:0]  cmd_pos, ptr, size;
   logic [7:0]  cmd_data;
`ifdef EDIT_REJECT_COUNT_EN
   logic [7:0]  reject_count;
`endif

   int total = 0;
   int bad   = 0;

   edit_cmd_sequencer #(.depth(5), .width(8)) dut (
      .clock(clock), .reset(reset), .b(b), .del(del), .ptrLeft(ptrLeft),
      .ptrRight(ptrRight), .eval(eval), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
      .cmd_pos(cmd_pos), .cmd_data(cmd_data), .ds_ready(ds_ready),
      .eval_start(eval_start), .eval_done(eval_done), .ptr(ptr), .size(size),
      .busy(busy),
`ifdef EDIT_REJECT_COUNT_EN
      .reject_count(reject_count),
`endif
      .rejected(rejected)
   );

   always #5 clock = ~clock;

   // Reference data store: applies each accepted command.
   int store[$];
   always @(posedge clock) begin
      if (reset) store.delete();
      else if (cmd_valid && ds_ready) begin
         if (cmd_op) store.delete(int'(cmd_pos));
         else        store.insert(int'(cmd_pos), int'(cmd_data));
      end
   end

   function automatic logic [39:0] pack_store();
      logic [39:0] r = '0;
      foreach (store[i]) r = (r << 8) | 40'(store[i]);
      return r;
   endfunction

   typedef struct {
      logic [15:0] b;
      logic del, lft, rgt, ev, rdy, done;
      logic v, op;
      logic [2:0] pos;
      logic [7:0] data;
      logic [2:0] p, s;
      logic bsy, rej, est;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [15:0] vb, input logic vdel, vl, vr, ve, vrdy, vdone,
                      input logic ev_v, ev_op, input logic [2:0] epos, input logic [7:0] edata,
                      input logic [2:0] ep, es, input logic ebsy, erej, eest);
      vec_t t;
      t.b = vb; t.del = vdel; t.lft = vl; t.rgt = vr; t.ev = ve; t.rdy = vrdy; t.done = vdone;
      t.v = ev_v; t.op = ev_op; t.pos = epos; t.data = edata; t.p = ep; t.s = es;
      t.bsy = ebsy; t.rej = erej; t.est = eest;
      vecs.push_back(t);
   endtask

   task automatic drive(input logic [15:0] vb, input logic vdel, vl, vr, ve, vrdy, vdone);
      @(negedge clock);
      b = vb; del = vdel; ptrLeft = vl; ptrRight = vr; eval = ve;
      ds_ready = vrdy; eval_done = vdone;
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string nm, input logic [21:0] exp);
      logic [21:0] act;
      act = {cmd_valid, cmd_op, cmd_pos, cmd_data, ptr, size, busy, rejected, eval_start};
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got v/op/pos/data/ptr/size/busy/rej/est=%b/%b/%0d/%0d/%0d/%0d/%b/%b/%b exp %b/%b/%0d/%0d/%0d/%0d/%b/%b/%b",
                  nm, act[21], act[20], act[19:17], act[16:9], act[8:6], act[5:3], act[2], act[1], act[0],
                  exp[21], exp[20], exp[19:17], exp[16:9], exp[8:6], exp[5:3], exp[2], exp[1], exp[0]);
      end
   endtask

   task automatic chk_val(input string nm, input logic [39:0] act, input logic [39:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got %h exp %h", nm, act, exp);
      end
   endtask

   task automatic run_vecs(input string tag);
      foreach (vecs[i]) begin
         drive(vecs[i].b, vecs[i].del, vecs[i].lft, vecs[i].rgt, vecs[i].ev, vecs[i].rdy, vecs[i].done);
         chk($sformatf("%s_row%0d", tag, i),
             {vecs[i].v, vecs[i].op, vecs[i].pos, vecs[i].data, vecs[i].p, vecs[i].s,
              vecs[i].bsy, vecs[i].rej, vecs[i].est});
      end
      vecs.delete();
   endtask

   initial begin
      reset = 1'b1; b = '0; del = 0; ptrLeft = 0; ptrRight = 0; eval = 0; ds_ready = 0; eval_done = 0;
      drive(16'h0, 0, 0, 0, 0, 0, 0);
      drive(16'h0, 0, 0, 0, 0, 0, 0);
      chk("reset_state", 22'd0);
      reset = 1'b0;

      //   b        del l r e rdy dn   v op pos data p  s  bsy rej est
      add(16'h0020, 0, 0, 0, 0, 1, 0,  1, 0, 0, 5,   0, 0, 1, 0, 0);
      add(16'h0000, 0, 0, 0, 0, 1, 0,  0, 0, 0, 5,   1, 1, 0, 0, 0);
      add(16'h0400, 0, 0, 0, 0, 1, 0,  1, 0, 1, 10,  1, 1, 1, 0, 0);
      add(16'h0000, 0, 0, 0, 0, 1, 0,  0, 0, 1, 10,  2, 2, 0, 0, 0);
      add(16'h0100, 0, 0, 0, 0, 1, 0,  1, 0, 2, 8,   2, 2, 1, 0, 0);
      add(16'h0000, 0, 0, 0, 0, 1, 0,  0, 0, 2, 8,   3, 3, 0, 0, 0);
      add(16'h2000, 0, 0, 0, 0, 1, 0,  1, 0, 3, 13,  3, 3, 1, 0, 0);
      add(16'h0000, 0, 0, 0, 0, 1, 0,  0, 0, 3, 13,  4, 4, 0, 0, 0);
      add(16'h0200, 0, 0, 0, 0, 1, 0,  1, 0, 4, 9,   4, 4, 1, 0, 0);
      add(16'h0000, 0, 0, 0, 0, 1, 0,  0, 0, 4, 9,   5, 5, 0, 0, 0);
      add(16'h0000, 0, 1, 0, 0, 1, 0,  0, 0, 4, 9,   4, 5, 0, 0, 0);
      add(16'h0000, 0, 0, 0, 0, 1, 0,  0, 0, 4, 9,   4, 5, 0, 0, 0);
      add(16'h0000, 0, 1, 0, 0, 1, 0,  0, 0, 4, 9,   3, 5, 0, 0, 0);
      add(16'h0000, 0, 0, 0, 0, 1, 0,  0, 0, 4, 9,   3, 5, 0, 0, 0);
      add(16'h0000, 1, 0, 0, 0, 1, 0,  1, 1, 2, 0,   3, 5, 1, 0, 0);
      add(16'h0000, 0, 0, 0, 0, 1, 0,  0, 1, 2, 0,   2, 4, 0, 0, 0);
      add(16'h0008, 0, 0, 0, 0, 1, 0,  1, 0, 2, 3,   2, 4, 1, 0, 0);
      add(16'h0000, 0, 0, 0, 0, 1, 0,  0, 0, 2, 3,   3, 5, 0, 0, 0);
      add(16'h0001, 0, 0, 0, 0, 1, 0,  0, 0, 2, 3,   3, 5, 0, 1, 0);
      add(16'h0000, 0, 0, 0, 0, 1, 0,  0, 0, 2, 3,   3, 5, 0, 0, 0);
      run_vecs("edit");
      chk_val("store_after_edit", pack_store(), 40'h050A030D09);
`ifdef EDIT_REJECT_COUNT_EN
      chk_val("reject_count_full", 40'(reject_count), 40'd1);
`endif

      //   b        del l r e rdy dn   v op pos data p  s  bsy rej est
      add(16'h0000, 1, 0, 0, 0, 0, 0,  1, 1, 2, 0,   3, 5, 1, 0, 0);
      add(16'h0000, 0, 0, 0, 0, 1, 0,  0, 1, 2, 0,   2, 4, 0, 0, 0);
      add(16'h0080, 0, 0, 0, 0, 0, 0,  1, 0, 2, 7,   2, 4, 1, 0, 0);
      add(16'h0000, 0, 0, 0, 0, 0, 0,  1, 0, 2, 7,   2, 4, 1, 0, 0);
      add(16'h0002, 0, 0, 0, 0, 0, 0,  1, 0, 2, 7,   2, 4, 1, 0, 0);
      add(16'h0000, 0, 0, 0, 0, 0, 0,  1, 0, 2, 7,   2, 4, 1, 0, 0);
      add(16'h0000, 0, 0, 0, 0, 1, 0,  0, 0, 2, 7,   3, 5, 0, 0, 0);
      add(16'h0000, 0, 1, 0, 0, 1, 0,  0, 0, 2, 7,   2, 5, 0, 0, 0);
      add(16'h0000, 0, 0, 0, 0, 1, 0,  0, 0, 2, 7,   2, 5, 0, 0, 0);
      add(16'h0080, 1, 0, 0, 0, 1, 0,  1, 1, 1, 0,   2, 5, 1, 0, 0);
      add(16'h0000, 0, 0, 0, 0, 1, 0,  0, 1, 1, 0,   1, 4, 0, 0, 0);
      add(16'h0006, 0, 0, 0, 0, 1, 0,  0, 1, 1, 0,   1, 4, 0, 1, 0);
      add(16'h0000, 0, 0, 0, 0, 1, 0,  0, 1, 1, 0,   1, 4, 0, 0, 0);
      add(16'h0000, 1, 0, 0, 0, 1, 0,  1, 1, 0, 0,   1, 4, 1, 0, 0);
      add(16'h0000, 0, 0, 0, 0, 1, 0,  0, 1, 0, 0,   0, 3, 0, 0, 0);
      add(16'h0000, 0, 0, 1, 0, 1, 0,  0, 1, 0, 0,   1, 3, 0, 0, 0);
      add(16'h0000, 0, 0, 0, 0, 1, 0,  0, 1, 0, 0,   1, 3, 0, 0, 0);
      add(16'h0000, 0, 0, 0, 1, 1, 0,  0, 1, 0, 0,   1, 3, 1, 0, 1);
      add(16'h0000, 0, 1, 0, 0, 1, 0,  0, 1, 0, 0,   1, 3, 1, 0, 0);
      add(16'h0000, 0, 0, 0, 0, 1, 0,  0, 1, 0, 0,   1, 3, 1, 0, 0);
      add(16'h0000, 0, 0, 0, 0, 1, 1,  0, 1, 0, 0,   1, 3, 0, 0, 0);
      add(16'h0000, 0, 0, 0, 0, 1, 1,  0, 1, 0, 0,   1, 3, 0, 0, 0);
      add(16'h0000, 0, 1, 0, 0, 1, 0,  0, 1, 0, 0,   0, 3, 0, 0, 0);
      add(16'h0000, 0, 0, 0, 0, 1, 0,  0, 1, 0, 0,   0, 3, 0, 0, 0);
      add(16'h0000, 0, 1, 0, 0, 1, 0,  0, 1, 0, 0,   0, 3, 0, 1, 0);
      add(16'h0000, 1, 0, 0, 0, 1, 0,  0, 1, 0, 0,   0, 3, 0, 1, 0);
      add(16'h0000, 0, 0, 0, 0, 1, 0,  0, 1, 0, 0,   0, 3, 0, 0, 0);
      run_vecs("stall_eval");
      chk_val("store_after_stall_eval", pack_store(), 40'h070D09);
`ifdef EDIT_REJECT_COUNT_EN
      chk_val("reject_count_total", 40'(reject_count), 40'd4);
`endif

      // Reset while a command is stalled in ISSUE.
      drive(16'h0080, 0, 0, 0, 0, 0, 0);
      chk("issue_before_reset", {1'b1, 1'b0, 3'd0, 8'd7, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0});
      reset = 1'b1;
      drive(16'h0000, 0, 0, 0, 0, 0, 0);
      chk("reset_mid_issue", 22'd0);
`ifdef EDIT_REJECT_COUNT_EN
      chk_val("reject_count_reset", 40'(reject_count), 40'd0);
`endif
      reset = 1'b0;
      drive(16'h0000, 0, 0, 1, 0, 1, 0);
      chk("right_at_end_rej", {1'b0, 1'b0, 3'd0, 8'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0});
      drive(16'h0000, 0, 0, 0, 1, 1, 0);
      chk("eval_empty_rej", {1'b0, 1'b0, 3'd0, 8'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0});
      drive(16'h0000, 0, 0, 0, 0, 1, 0);
      chk("idle_after_rej", 22'd0);
      chk_val("store_after_reset", pack_store(), 40'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/edit_cmd_sequencer.md
Name: edit_cmd_sequencer

Overview:
- Sits between the keypad inputs (b, del, ptrLeft, ptrRight, eval) and the expression data store inside parent.
- Edge-detects and arbitrates raw key events and owns the cursor pointer and token count.
- Issues one insert/delete command at a time to the data store over a valid/ready handshake.
- Sequences the evaluation handoff and blocks editing until the evaluator finishes.

Parameters:
- depth, 5, number of token slots in the data store.
- width, 8, token width in bits; must be >= 4.
- Local: pw = $clog2(depth+1), width of ptr/size.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- b  in  16  one-hot key lines: 0-9 digits, 10 '+', 11 '-', 12 '*', 13 '/', 14 '(', 15 ')'.
- del  in  1  delete token left of cursor.
- ptrLeft  in  1  move cursor left.
- ptrRight  in  1  move cursor right.
- eval  in  1  request evaluation.
- cmd_valid  out  1  command to data store is valid.
- cmd_op  out  1  0 = insert, 1 = delete.
- cmd_pos  out  pw  slot index: insert at ptr, delete at ptr-1.
- cmd_data  out  width  token for insert: key index zero-extended; 0 for delete.
- ds_ready  in  1  data store accepts the command this cycle.
- eval_start  out  1  one-cycle pulse to evaluator.
- eval_done  in  1  evaluator finished (single-cycle pulse).
- ptr  out  pw  cursor, 0..size.
- size  out  pw  tokens stored, 0..depth.
- busy  out  1  high in any state other than IDLE.
- rejected  out  1  one-cycle pulse when an event is refused.

Behaviour:
- Reset values: all outputs 0; state IDLE; edge-detect history = 0.
- Events: rising edge of each input, i.e. input & ~prev. prev registers update every cycle in every state.
- An event is acted on only in IDLE. Events arriving outside IDLE are dropped silently, with no rejected pulse.
- Priority within one cycle: eval > del > ptrLeft > ptrRight > b. Lower-priority events in the same cycle are discarded.
- b edge with more than one bit rising -> rejected.
- FSM states: IDLE, ISSUE, EVAL_WAIT.
- IDLE, key event:
  - size == depth -> rejected.
  - Otherwise latch cmd_op=0, cmd_pos=ptr, cmd_data=key index; go to ISSUE.
- IDLE, del event:
  - ptr == 0 -> rejected.
  - Otherwise latch cmd_op=1, cmd_pos=ptr-1; go to ISSUE.
- IDLE, ptrLeft event: ptr > 0 -> ptr-1 on the next edge; else rejected. No data store traffic.
- IDLE, ptrRight event: ptr < size -> ptr+1 on the next edge; else rejected. No data store traffic.
- IDLE, eval event:
  - size == 0 -> rejected.
  - Otherwise eval_start pulses the next cycle; go to EVAL_WAIT.
- ISSUE:
  - cmd_valid=1 with op/pos/data held stable until ds_ready.
  - On the handshake cycle: insert -> ptr+1, size+1; delete -> ptr-1, size-1; return to IDLE.
  - cmd_valid deasserts the following cycle.
- EVAL_WAIT: hold until eval_done, then return to IDLE. ptr and size are unchanged.
- eval_done outside EVAL_WAIT is ignored.
- Latency:
  - Event at cycle N -> cmd_valid high from cycle N+1.
  - Pointer moves are visible at N+1.
  - Back-to-back commands: a minimum of 2 cycles per insert/delete with ds_ready tied high.
- Invariant: 0 <= ptr <= size <= depth at all times.
- Reset mid-ISSUE or mid-EVAL_WAIT: cmd_valid, eval_start and busy are 0 on the next cycle; ptr=size=0. The data store shares the same reset.

Optional Feature:
- Macro: EDIT_REJECT_COUNT_EN.
- When defined:
  - Extra output reject_count [7:0].
  - Increments on every rejected pulse and saturates at 255.
  - Cleared by reset.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Keys 5,10,8,13,9 with ds_ready=1 -> five inserts at pos 0..4 with data 5,10,8,13,9; ptr=5, size=5, store holds [5][10][8][13][9].
- From that state: ptrLeft x2, del, key 3 -> ptr 5->3; delete at pos 2; insert data 3 at pos 2; final [5][10][3][13][9], ptr=3, size=5.
- Sixth key with size=5 -> no cmd_valid; rejected pulses; with EDIT_REJECT_COUNT_EN, reject_count=1.
- ds_ready held low 4 cycles after an insert -> cmd_valid/op/pos/data stable for 4 cycles; ptr/size update only on the ready cycle; a key pressed meanwhile is dropped.
- del and key 7 rising in the same cycle at ptr=2 -> only delete at pos 1 issued. Then b=0x0006 -> rejected, no command.
- eval with size=3 -> eval_start one pulse, busy high. ptrLeft during EVAL_WAIT is ignored. eval_done -> IDLE, ptr unchanged; reset asserted while in ISSUE clears all outputs on the next cycle.
